// File: rtl/vnu.sv
// vnu: min-sum LDPC variable node unit.
// Two-stage pipeline: stage 1 registers the sign-extended check messages and
// the posterior total (channel LLR + all messages); stage 2 forms each
// extrinsic message as total - r_i with symmetric saturation, plus the hard
// decision taken from the sign of the total.
// Optional feature: define VNU_ET_EN to build the hard-decision stability
// counter used for early termination; otherwise stable is tied low.

// Per-edge extrinsic message: total - r_i, clamped to +/-(2^(data_w-1)-1).
module vnu_lane #(
  parameter int SUM_W  = 11,
  parameter int data_w = 11
) (
  input  logic [SUM_W-1:0]  i_total,
  input  logic [SUM_W-1:0]  i_rx,
  output logic [data_w-1:0] o_q
);
  // Difference width wide enough for both the subtraction and the clamp limits.
  localparam int DW = (SUM_W > data_w) ? SUM_W + 1 : data_w + 1;
  localparam logic signed [DW-1:0] MAXV = {{(DW-data_w+1){1'b0}}, {(data_w-1){1'b1}}};
  localparam logic signed [DW-1:0] MINV = -MAXV;

  logic signed [DW-1:0] w_diff;
  assign w_diff = DW'($signed(i_total)) - DW'($signed(i_rx));

  // Symmetric saturation; -2^(data_w-1) is never produced.
  always_comb begin
    o_q = w_diff[data_w-1:0];
    if (w_diff > MAXV)      o_q = MAXV[data_w-1:0];
    else if (w_diff < MINV) o_q = MINV[data_w-1:0];
  end
endmodule

module vnu #(
  parameter  int DV       = 3,
  parameter  int res_w    = 8,
  parameter  int ext_w    = 3,
  parameter  int cnt_w    = 3,
  parameter  int STABLE_N = 3,
  localparam int data_w   = res_w + ext_w
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [res_w-1:0]     llr,
  input  logic [res_w*DV-1:0]  r,
  output logic [data_w*DV-1:0] q,
  output logic                 hd,
  output logic                 valid,
  output logic                 stable
);
  // Sum of DV+1 res_w-bit terms plus a guard bit: cannot overflow.
  localparam int SUM_W = res_w + $clog2(DV + 1) + 1;

  if (STABLE_N > (2**cnt_w) - 1) begin : g_bad_stable_n
    $error("STABLE_N does not fit in cnt_w bits");
  end

  logic signed [res_w-1:0]        r_llr;
  logic [1:0]                     r_vld_pipe;   // [0] stage-1 valid, [1] output strobe
  logic [DV-1:0][SUM_W-1:0]       r_rx;
  logic signed [SUM_W-1:0]        r_total;
  logic [DV-1:0][data_w-1:0]      r_q;
  logic                           r_hd;

  logic [DV-1:0][SUM_W-1:0]       w_rx;
  logic signed [SUM_W-1:0]        w_sum;
  logic [DV-1:0][data_w-1:0]      w_q;
  logic                           w_hd_new;

  // Per-edge sign extension, extrinsic lane and output packing.
  for (genvar i = 0; i < DV; i++) begin : g_edge
    assign w_rx[i] = {{(SUM_W-res_w){r[i*res_w+res_w-1]}}, r[i*res_w +: res_w]};

    vnu_lane #(.SUM_W(SUM_W), .data_w(data_w)) u_lane (
      .i_total (r_total),
      .i_rx    (r_rx[i]),
      .o_q     (w_q[i])
    );

    assign q[i*data_w +: data_w] = r_q[i];
  end

  // Posterior total: channel LLR plus every incoming message.
  always_comb begin
    w_sum = SUM_W'(r_llr);
    for (int i = 0; i < DV; i++) w_sum = w_sum + $signed(w_rx[i]);
  end

  // Sign of the total is the hard decision; zero maps to 0.
  assign w_hd_new = r_total[SUM_W-1];

  // Channel register and both pipeline stages. load flushes stage 1 only;
  // a result already in stage 1 still completes on the load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_llr      <= '0;
      r_vld_pipe <= '0;
      r_rx       <= '0;
      r_total    <= '0;
      r_q        <= '0;
      r_hd       <= 1'b0;
    end else begin
      r_vld_pipe[1] <= r_vld_pipe[0];
      if (r_vld_pipe[0]) begin
        r_q  <= w_q;
        r_hd <= w_hd_new;
      end
      if (load) begin
        r_llr         <= llr;
        r_vld_pipe[0] <= 1'b0;
      end else begin
        r_vld_pipe[0] <= en;
        if (en) begin
          r_rx    <= w_rx;
          r_total <= w_sum;
        end
      end
    end
  end

  assign hd    = r_hd;
  assign valid = r_vld_pipe[1];

`ifdef VNU_ET_EN
  localparam logic [cnt_w-1:0] STABLE_V = cnt_w'(STABLE_N);

  logic [cnt_w-1:0] r_cnt;
  logic             r_hd_prev;
  logic             r_first;

  // Count consecutive identical hard decisions; load restarts the history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_hd_prev <= 1'b0;
      r_first   <= 1'b1;
    end else if (load) begin
      r_cnt   <= '0;
      r_first <= 1'b1;
    end else if (r_vld_pipe[0]) begin
      r_hd_prev <= w_hd_new;
      if (r_first) begin
        r_cnt   <= '0;
        r_first <= 1'b0;
      end else if (w_hd_new == r_hd_prev) begin
        if (r_cnt != STABLE_V) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign stable = (r_cnt == STABLE_V);
`else
  assign stable = 1'b0;
`endif
endmodule

// File: tb/tb_vnu.sv
// Bench for vnu: a default-width instance and an ext_w=0 instance driven in
// parallel, checked every cycle against an integer model, plus literal checks.
module tb_vnu;
  localparam int DV = 3, RW = 8, EW = 3, DW = RW + EW, DW0 = RW, SN = 3;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0;
  logic [RW-1:0]    llr = '0;
  logic [RW*DV-1:0] r = '0;
  logic [DW*DV-1:0]  q;
  logic [DW0*DV-1:0] q0;
  logic hd, valid, stable, hd0, valid0, stable0;

  always #5 clk = ~clk;

  vnu #(.DV(DV), .res_w(RW), .ext_w(EW), .cnt_w(3), .STABLE_N(SN)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .llr(llr), .r(r),
    .q(q), .hd(hd), .valid(valid), .stable(stable));

  vnu #(.DV(DV), .res_w(RW), .ext_w(0), .cnt_w(3), .STABLE_N(SN)) dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .llr(llr), .r(r),
    .q(q0), .hd(hd0), .valid(valid0), .stable(stable0));

  int n_chk = 0, n_fail = 0;
  bit run = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic signed [31:0] qd(input int i);
    return $signed(q[i*DW +: DW]);
  endfunction
  function automatic logic signed [31:0] q0d(input int i);
    return $signed(q0[i*DW0 +: DW0]);
  endfunction
  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << (w - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx) return -mx;
    return v;
  endfunction
  function automatic int rin(input int i);
    logic [RW-1:0] t;
    t = r[i*RW +: RW];
    return int'($signed(t));
  endfunction

  // Behavioural model: integer posterior arithmetic, one pending computation.
  int m_llr = 0, p_tot = 0, m_cnt = 0;
  int p_r[DV];
  int e_q[DV], e_q0[DV];
  bit p_v = 0, e_valid = 0, e_hd = 0, m_first = 1, m_hd_prev = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_llr = 0; p_v = 0; p_tot = 0; e_valid = 0; e_hd = 0;
      m_first = 1; m_cnt = 0; m_hd_prev = 0;
      for (int i = 0; i < DV; i++) begin e_q[i] = 0; e_q0[i] = 0; end
    end else begin
      e_valid = p_v;
      if (p_v) begin
        for (int i = 0; i < DV; i++) begin
          e_q[i]  = sat(p_tot - p_r[i], DW);
          e_q0[i] = sat(p_tot - p_r[i], DW0);
        end
        e_hd = (p_tot < 0);
        if (m_first) begin m_first = 0; m_cnt = 0; end
        else if (e_hd == m_hd_prev) m_cnt = (m_cnt < SN) ? m_cnt + 1 : SN;
        else m_cnt = 0;
        m_hd_prev = e_hd;
      end
      if (load) begin
        m_llr = int'($signed(llr)); p_v = 0; m_first = 1; m_cnt = 0;
      end else if (en) begin
        p_v = 1; p_tot = m_llr;
        for (int i = 0; i < DV; i++) begin p_r[i] = rin(i); p_tot += p_r[i]; end
      end else begin
        p_v = 0;
      end
    end
  end

  function automatic bit e_stable();
`ifdef VNU_ET_EN
    return (m_cnt == SN);
`else
    return 1'b0;
`endif
  endfunction

  localparam bit ET = `ifdef VNU_ET_EN 1'b1 `else 1'b0 `endif ;

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    if (run) begin
      chk("valid", valid, e_valid);
      chk("valid0", valid0, e_valid);
      chk("hd", hd, e_hd);
      chk("hd0", hd0, e_hd);
      chk("stable", stable, e_stable());
      chk("stable0", stable0, e_stable());
      for (int i = 0; i < DV; i++) begin
        chk($sformatf("q[%0d]", i), qd(i), e_q[i]);
        chk($sformatf("q0[%0d]", i), q0d(i), e_q0[i]);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic set_r(input int a, input int b, input int c);
    logic [RW-1:0] ta, tb, tc;
    ta = RW'(a); tb = RW'(b); tc = RW'(c);
    r = {tc, tb, ta};
  endtask
  task automatic do_load(input int v);
    load = 1'b1; llr = RW'(v); cyc(); load = 1'b0;
  endtask
  task automatic do_en(input int a, input int b, input int c);
    en = 1'b1; set_r(a, b, c); cyc(); en = 1'b0;
  endtask
  task automatic chk_q(input string nm, input int a, input int b, input int c);
    chk({nm, "_q0"}, qd(0), a);
    chk({nm, "_q1"}, qd(1), b);
    chk({nm, "_q2"}, qd(2), c);
  endtask

  function automatic int rnd_val();
    case ($urandom_range(7))
      0: return -128;
      1: return 127;
      default: return int'($signed(8'($urandom_range(255))));
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    run = 1;
    chk("rst_valid", valid, 0);
    chk("rst_hd", hd, 0);
    chk("rst_stable", stable, 0);
    chk_q("rst", 0, 0, 0);

    // Default widths: total 19.
    do_load(10);
    do_en(5, -3, 7);
    chk("lat_valid_early", valid, 0);
    cyc();
    chk("t1_valid", valid, 1);
    chk("t1_hd", hd, 0);
    chk_q("t1", 14, 22, 12);
    cyc();
    chk("t1_strobe_end", valid, 0);
    chk_q("t1_hold", 14, 22, 12);

    // Negative posterior: total -11.
    do_load(-20);
    do_en(3, 4, 2);
    cyc();
    chk("t2_hd", hd, 1);
    chk_q("t2", -14, -15, -13);

    // Saturation on the 8-bit instance; the 11-bit instance is unclamped.
    do_load(127);
    do_en(127, 127, 127);
    cyc();
    for (int i = 0; i < DV; i++) begin
      chk("sat_pos_q0w", q0d(i), 127);
      chk("sat_pos_qw", qd(i), 381);
    end
    do_load(-128);
    do_en(-128, -128, -128);
    cyc();
    for (int i = 0; i < DV; i++) begin
      chk("sat_neg_q0w", q0d(i), -127);
      chk("sat_neg_qw", qd(i), -384);
    end

    // Back-to-back: four accepted en, four consecutive strobes.
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_r(k + 1, -k, 2 * k);
      cyc();
      if (k == 1) chk("b2b_first_q0", qd(0), -128);
      if (k >= 1) chk("b2b_valid", valid, 1);
    end
    en = 1'b0;
    cyc();
    chk("b2b_valid_last", valid, 1);
    cyc();
    chk("b2b_valid_off", valid, 0);

    // load and en together: en is dropped.
    load = 1'b1; en = 1'b1; llr = '0; set_r(9, 9, 9);
    cyc();
    load = 1'b0; en = 1'b0;
    cyc();
    chk("load_en_no_valid", valid, 0);
    cyc();
    chk("load_en_no_valid2", valid, 0);

    // Stability: hd 0,0,0,0,1 then 0,0,0,0 then load.
    do_load(0);
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) set_r(1, 1, 1); else set_r(-5, -5, -5);
      cyc();
    end
    chk("stab_rise", stable, ET);
    en = 1'b0;
    cyc();
    chk("stab_drop_hd", hd, 1);
    chk("stab_drop", stable, 0);
    en = 1'b1;
    set_r(1, 1, 1);
    for (int k = 0; k < 4; k++) cyc();
    en = 1'b0;
    cyc();
    chk("stab_rise2", stable, ET);
    do_load(0);
    chk("stab_load_clr", stable, 0);

    // Reset mid-pipeline discards the in-flight result and clears llr_reg.
    do_load(40);
    do_en(50, 50, 50);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_valid", valid, 0);
    chk("midrst_hd", hd, 0);
    chk("midrst_stable", stable, 0);
    chk_q("midrst", 0, 0, 0);
    cyc();
    chk("midrst_no_valid", valid, 0);
    do_en(0, 0, 0);
    cyc();
    chk("midrst_llr_valid", valid, 1);
    chk_q("midrst_llr", 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(199) < 2);
      load = ($urandom_range(99) < 10);
      en   = ($urandom_range(99) < 70);
      llr  = RW'(rnd_val());
      set_r(rnd_val(), rnd_val(), rnd_val());
      cyc();
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
    cyc(); cyc();
    run = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vnu.md
# vnu

Variable node unit for the min-sum LDPC decoder: the counterpart of the check node unit. Each active cycle it takes DV check-to-variable messages plus the stored channel LLR and produces DV extended-width variable-to-check messages and a hard-decision bit. The messages leave through the same packed bus format the check node unit consumes. The block is a two-stage pipeline with a channel-LLR register and an optional hard-decision stability counter for early termination.

## Interface
- DV, 3, variable node degree (number of edges).
- res_w, 8, width of check-to-variable messages and channel LLR (signed two's complement).
- ext_w, 3, extra magnitude bits on outgoing messages.
- cnt_w, 3, stability counter width.
- STABLE_N, 3, consecutive identical hard decisions required to assert stable (must be ≤ 2^cnt_w−1).
- data_w = res_w + ext_w (localparam).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  sample r and start a computation.
- load  in  1  capture llr into the channel register.
- llr  in  res_w  channel LLR, signed.
- r  in  res_w*DV  check-to-variable messages; edge i at r[i*res_w +: res_w], signed.
- q  out  data_w*DV  variable-to-check messages; edge i at q[i*data_w +: data_w], signed.
- hd  out  1  hard decision; 1 when the posterior is negative.
- valid  out  1  one-cycle strobe; q and hd are new.
- stable  out  1  early-termination flag (see Configuration).

## Operation
- Channel register: on load, llr_reg <= llr. Also flushes the pipeline: stage-1 valid is cleared and valid is not produced from that cycle's en. Clears the stability history.
- load and en in the same cycle: load wins and en is ignored.
- Stage 1 (edge where en=1 and load=0):
  - Register each r_i, sign-extended to sum width.
  - Register total = llr_reg + Σ r_i.
  - Sum width is res_w + ceil(log2(DV+1)) + 1, so the sum never overflows.
- Stage 2 (next edge):
  - q_i <= sat(total − r_i).
  - hd <= sign bit of total; total = 0 gives hd = 0.
  - valid <= 1.
- Saturation is symmetric to [−(2^(data_w−1)−1), +(2^(data_w−1)−1)]. −2^(data_w−1) is never emitted, so the downstream abs cannot overflow.
- Hold behaviour: q and hd hold between strobes. valid is high for exactly one cycle per accepted en.
- Back-to-back: en on consecutive cycles is accepted with no bubbles.
- Stability counter (VNU_ET_EN only), updated on each stage-2 result:
  - First result after reset or load: cnt <= 0, hd_prev <= hd.
  - Later results: if hd equals hd_prev, cnt increments, saturating at STABLE_N; otherwise cnt <= 0. hd_prev always updates.
  - stable = (cnt == STABLE_N).

## Timing
- Latency: en sampled on edge E0; q, hd and valid update on edge E0+1 and are visible in the following cycle. valid is high for that one cycle.
- Throughput: one computation per cycle.
- load effect: llr_reg is usable by an en on the edge after load's edge.
- Flush: an en accepted on the edge before load still completes on the load edge (stage 2 is not cancelled). Stage-1 data captured on the load edge does not exist.
- Reset values: q = 0, hd = 0, valid = 0, stable = 0, llr_reg = 0, cnt = 0, stage-1 valid = 0, first-result flag set.
- rst mid-pipeline: any in-flight result is discarded and no valid follows. rst has priority over load and en.

## Configuration
- VNU_ET_EN defined: hd_prev, the counter and the first-result flag are built, and stable behaves as described.
- VNU_ET_EN undefined: none of that logic exists and stable is tied to 0.

## Test plan
- Defaults. Reset, load llr=10, then en with r=(5,−3,7):
  - Two cycles later valid=1 for one cycle.
  - q=(14,22,12), hd=0.
- Negative posterior. llr=−20, r=(3,4,2): total=−11, q=(−14,−15,−13), hd=1.
- Saturation, with ext_w=0 (data_w=8):
  - llr=127, r=(127,127,127): q=(127,127,127).
  - llr=−128, r=(−128,−128,−128): q=(−127,−127,−127).
- Back-to-back. en on 4 consecutive cycles with distinct r gives 4 consecutive valid strobes, in order with correct values. Then load and en in the same cycle gives no valid two cycles later.
- Stability (VNU_ET_EN). Five results with hd=0,0,0,0,1:
  - stable rises on the 4th result (cnt=3).
  - stable drops on the 5th.
  - A subsequent load clears it.
  - Repeat without the macro: stable is always 0.
- Reset mid-operation. en on edge E0 and rst on E0+1: valid stays 0, and all outputs and llr_reg are 0.
